// File: rtl/multi_port_register_file.sv
// Multi-port register file with busy scoreboard, reset-loaded parameters and stat taps.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to readers and releases stalls.
module multi_port_register_file #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned FLOORS_IDX = 2,
  parameter int unsigned RESIST_IDX = 3
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  output logic [NUM_RD-1:0]        rd_stall_o,
  input  logic                     w0_en_i,
  input  logic [ADDR_W-1:0]        w0_addr_i,
  input  logic [DATA_W-1:0]        w0_data_i,
  input  logic                     w1_en_i,
  input  logic [ADDR_W-1:0]        w1_addr_i,
  input  logic [DATA_W-1:0]        w1_data_i,
  input  logic                     reserve_en_i,
  input  logic [ADDR_W-1:0]        reserve_addr_i,
  output logic [2**ADDR_W-1:0]     busy_o,
  output logic                     reserve_conflict_o,
  input  logic [DATA_W-1:0]        initial_floors_i,
  input  logic [DATA_W-1:0]        initial_resistance_i,
  output logic [DATA_W-1:0]        attempt_count_o,
  output logic [DATA_W-1:0]        broken_count_o,
  output logic                     is_last_broken_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
  logic                     reserve_conflict_q, reserve_conflict_d;

  // w1 is applied after w0 so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (w0_en_i && (w0_addr_i != '0)) regs_d[w0_addr_i] = w0_data_i;
    if (w1_en_i && (w1_addr_i != '0)) regs_d[w1_addr_i] = w1_data_i;
    regs_d[0] = '0;
  end

  // Reserve is applied last so a same-cycle reserve keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (w0_en_i) busy_d[w0_addr_i] = 1'b0;
    if (w1_en_i) busy_d[w1_addr_i] = 1'b0;
    if (reserve_en_i) busy_d[reserve_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign reserve_conflict_d = reserve_en_i & busy_q[reserve_addr_i] & (reserve_addr_i != '0);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              fwd_hit;
    logic              stall;
    logic [DATA_W-1:0] word;

    assign addr = rd_addr_i[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit0    = w0_en_i & (w0_addr_i == addr) & (addr != '0);
    assign hit1    = w1_en_i & (w1_addr_i == addr) & (addr != '0);
    assign fwd_hit = hit0 | hit1;
    assign word    = (addr == '0) ? '0 :
                     hit1         ? w1_data_i :
                     hit0         ? w0_data_i : regs_q[addr];
`else
    assign fwd_hit = 1'b0;
    assign word    = (addr == '0) ? '0 : regs_q[addr];
`endif
    assign stall                         = rd_en_i[g] & busy_q[addr] & ~fwd_hit;
    assign rd_stall_o[g]                 = stall;
    assign rd_valid_d[g]                 = rd_en_i[g] & ~stall;
    assign rd_data_d[g*DATA_W +: DATA_W] = (rd_en_i[g] & ~stall) ? word : '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      if (FLOORS_IDX != 0) regs_q[FLOORS_IDX] <= initial_floors_i;
      if (RESIST_IDX != 0) regs_q[RESIST_IDX] <= initial_resistance_i;
      busy_q             <= '0;
      rd_data_q          <= '0;
      rd_valid_q         <= '0;
      reserve_conflict_q <= 1'b0;
    end else begin
      regs_q             <= regs_d;
      busy_q             <= busy_d;
      rd_data_q          <= rd_data_d;
      rd_valid_q         <= rd_valid_d;
      reserve_conflict_q <= reserve_conflict_d;
    end
  end

  assign rd_data_o          = rd_data_q;
  assign rd_valid_o         = rd_valid_q;
  assign busy_o             = busy_q;
  assign reserve_conflict_o = reserve_conflict_q;
  assign attempt_count_o    = regs_q[4];
  assign broken_count_o     = regs_q[5];
  assign is_last_broken_o   = regs_q[6][0];

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed self-checking bench for multi_port_register_file (default 2 read ports, 32x32).
module tb_multi_port_register_file;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid, rd_stall;
  logic                     w0_en, w1_en, reserve_en;
  logic [ADDR_W-1:0]        w0_addr, w1_addr, reserve_addr;
  logic [DATA_W-1:0]        w0_data, w1_data, floors, resist;
  logic [31:0]              busy;
  logic                     conflict, last_broken;
  logic [DATA_W-1:0]        attempts, broken;

  int total = 0;
  int bad   = 0;

  multi_port_register_file dut (
    .clock_i             (clock),
    .reset_i             (reset),
    .rd_en_i             (rd_en),
    .rd_addr_i           (rd_addr),
    .rd_data_o           (rd_data),
    .rd_valid_o          (rd_valid),
    .rd_stall_o          (rd_stall),
    .w0_en_i             (w0_en),
    .w0_addr_i           (w0_addr),
    .w0_data_i           (w0_data),
    .w1_en_i             (w1_en),
    .w1_addr_i           (w1_addr),
    .w1_data_i           (w1_data),
    .reserve_en_i        (reserve_en),
    .reserve_addr_i      (reserve_addr),
    .busy_o              (busy),
    .reserve_conflict_o  (conflict),
    .initial_floors_i    (floors),
    .initial_resistance_i(resist),
    .attempt_count_o     (attempts),
    .broken_count_o      (broken),
    .is_last_broken_o    (last_broken)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    w0_en = 0; w0_addr = '0; w0_data = '0;
    w1_en = 0; w1_addr = '0; w1_data = '0;
    reserve_en = 0; reserve_addr = '0;
  endtask

  task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rd_en = en; rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    floors = 32'd100; resist = 32'd36;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", rd_valid, 2'b00);
    chk("rst_data", rd_data, 64'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_conflict", conflict, 1'b0);

    // Reset-loaded registers.
    rd(2'b11, 5'd2, 5'd3); tick();
    chk("rd_r2", rd_data[31:0], 32'd100);
    chk("rd_r3", rd_data[63:32], 32'd36);
    chk("rd_valid11", rd_valid, 2'b11);

    rd(2'b01, 5'd0, 5'd0); tick();
    chk("rd_r0", rd_data[31:0], 32'd0);
    chk("rd_valid01", rd_valid, 2'b01);
    chk("rd_p1_idle", rd_data[63:32], 32'd0);

    // Write collision: w1 wins. Then r0 write ignored.
    idle();
    w0_en = 1; w0_addr = 5'd7; w0_data = 32'd5;
    w1_en = 1; w1_addr = 5'd7; w1_data = 32'd9;
    tick();
    idle();
    w0_en = 1; w0_addr = 5'd0; w0_data = 32'd123;
    rd(2'b10, 5'd0, 5'd7);
    tick();
    chk("rd_r7_w1wins", rd_data[63:32], 32'd9);
    idle();
    rd(2'b01, 5'd0, 5'd0); tick();
    chk("rd_r0_after_write", rd_data[31:0], 32'd0);
    chk("busy0", busy[0], 1'b0);

    // Scoreboard stall on r8.
    idle();
    reserve_en = 1; reserve_addr = 5'd8; tick();
    chk("busy8_set", busy[8], 1'b1);
    chk("conflict_first", conflict, 1'b0);
    idle();
    rd(2'b01, 5'd8, 5'd0); #1;
    chk("stall8", rd_stall, 2'b01);
    tick();
    chk("stall8_valid", rd_valid, 2'b00);
    chk("stall8_data", rd_data, 64'h0);
    w1_en = 1; w1_addr = 5'd8; w1_data = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_nostall", rd_stall, 2'b00);
    tick();
    chk("bypass_data", rd_data[31:0], 32'h55);
    chk("bypass_valid", rd_valid, 2'b01);
    chk("busy8_clear", busy[8], 1'b0);
`else
    chk("wb_cycle_stall", rd_stall, 2'b01);
    tick();
    chk("wb_cycle_valid", rd_valid, 2'b00);
    chk("busy8_clear", busy[8], 1'b0);
    w1_en = 0; #1;
    chk("after_wb_nostall", rd_stall, 2'b00);
    tick();
    chk("after_wb_data", rd_data[31:0], 32'h55);
    chk("after_wb_valid", rd_valid, 2'b01);
`endif

    // Reserve conflict and reserve-over-write priority on r9.
    idle();
    reserve_en = 1; reserve_addr = 5'd9; tick();
    chk("conflict_r9_first", conflict, 1'b0);
    tick();
    chk("conflict_r9_pulse", conflict, 1'b1);
    idle(); tick();
    chk("conflict_r9_drop", conflict, 1'b0);
    reserve_en = 1; reserve_addr = 5'd9;
    w0_en = 1; w0_addr = 5'd9; w0_data = 32'd1;
    tick();
    chk("busy9_reserve_wins", busy[9], 1'b1);
    idle();
    reserve_en = 1; reserve_addr = 5'd0; tick();
    chk("reserve_r0_busy", busy[0], 1'b0);
    chk("reserve_r0_conflict", conflict, 1'b0);

    // Stat taps.
    idle();
    w0_en = 1; w0_addr = 5'd4; w0_data = 32'd3;
    w1_en = 1; w1_addr = 5'd5; w1_data = 32'd1;
    tick();
    idle();
    w0_en = 1; w0_addr = 5'd6; w0_data = 32'd1;
    tick();
    idle();
    chk("attempt_count", attempts, 32'd3);
    chk("broken_count", broken, 32'd1);
    chk("is_last_broken", last_broken, 1'b1);

    // Mid-test reset beats same-cycle write, reserve and read.
    reset = 1;
    w0_en = 1; w0_addr = 5'd4; w0_data = 32'd7;
    reserve_en = 1; reserve_addr = 5'd10;
    rd(2'b11, 5'd4, 5'd5);
    tick();
    reset = 0;
    idle();
    chk("mrst_busy", busy, 32'h0);
    chk("mrst_attempts", attempts, 32'd0);
    chk("mrst_broken", broken, 32'd0);
    chk("mrst_last", last_broken, 1'b0);
    chk("mrst_valid", rd_valid, 2'b00);
    chk("mrst_conflict", conflict, 1'b0);
    rd(2'b11, 5'd2, 5'd3); tick();
    chk("mrst_r2", rd_data[31:0], 32'd100);
    chk("mrst_r3", rd_data[63:32], 32'd36);
    rd(2'b11, 5'd7, 5'd7); tick();
    chk("mrst_r7_p0", rd_data[31:0], 32'd0);
    chk("mrst_r7_p1", rd_data[63:32], 32'd0);
    chk("mrst_r7_valid", rd_valid, 2'b11);
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
